// File: rtl/dcache_wbuf_pkg.sv
// dcache_wbuf_pkg
// Shared types and constants for the data-cache write buffer.
//   wbuf_state_e  : downstream memory-port state (IDLE, DRAIN, READ)
//   wbuf_entry_t  : one buffer entry (valid, line tag, line data) at the
//                   default 32-bit address / 256-bit line geometry
//   LINE_OFFSET_W : byte-offset bits inside a line (32-byte lines)
package dcache_wbuf_pkg;

    localparam int LINE_OFFSET_W = 5;
    localparam int WBUF_ADDR_W   = 32;
    localparam int WBUF_LINE_W   = 256;
    localparam int WBUF_TAG_W    = WBUF_ADDR_W - LINE_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic                   valid;
        logic [WBUF_TAG_W-1:0]  tag;
        logic [WBUF_LINE_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/dcache_write_buffer_fifo.sv
// wbuf_fifo
// Circular line storage for the write buffer.
//   push/push_tag/push_data : enqueue a new entry at the tail
//   pop                     : retire the head entry
//   cwr/cwr_idx/cwr_data    : overwrite the data of an existing entry (coalesce)
//   cmp_tag -> match_vec    : per-entry "valid and tag equal" vector
//   rd_idx  -> rd_data      : random read port (forwarding)
//   head_idx/head_tag/head_data, count : head view and occupancy 0..DEPTH
module wbuf_fifo
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 27,
    parameter int LINE_W = 256,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [LINE_W-1:0] push_data,
    input  logic              pop,
    input  logic              cwr,
    input  logic [PTR_W-1:0]  cwr_idx,
    input  logic [LINE_W-1:0] cwr_data,
    input  logic [TAG_W-1:0]  cmp_tag,
    output logic [DEPTH-1:0]  match_vec,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data,
    output logic [PTR_W-1:0]  head_idx,
    output logic [TAG_W-1:0]  head_tag,
    output logic [LINE_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    logic [DEPTH-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [DEPTH];
    logic [LINE_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    // Valid bits, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag/data payload; qualified by valid_r so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_r[tail_r]  <= push_tag;
            data_r[tail_r] <= push_data;
        end
        if (cwr) begin
            data_r[cwr_idx] <= cwr_data;
        end
    end

    // Per-entry tag comparison against the current upstream address.
    always_comb begin
        match_vec = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_r[i] & (tag_r[i] == cmp_tag);
        end
    end

    assign rd_data   = data_r[rd_idx];
    assign head_idx  = head_r;
    assign head_tag  = tag_r[head_r];
    assign head_data = data_r[head_r];
    assign count     = count_r;

endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
// Line write buffer between the data cache memory port and data memory.
// Write-backs are acknowledged one cycle after acceptance and drained to
// memory in FIFO order; writes to an already buffered line (other than the
// one currently being written to memory) are merged into that entry.
// Read misses go to memory with priority over pending drains.
// Optional feature macro: WBUF_FORWARD_EN
//   defined   : reads hitting a buffered line return the youngest copy in one cycle
//   undefined : reads hitting a buffered line stall until that line has drained
// Ports:
//   clk_i, rst_i (async, active-high)
//   up_*  : cache side  (enable/write/addr/data in, ack/data out)
//   mem_* : memory side (enable/write/addr/data out, ack/data in)
module dcache_write_buffer
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              up_enable_i,
    input  logic              up_write_i,
    input  logic [ADDR_W-1:0] up_addr_i,
    input  logic [LINE_W-1:0] up_data_i,
    output logic              up_ack_o,
    output logic [LINE_W-1:0] up_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int TAG_W = ADDR_W - LINE_OFFSET_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_state_e       state_r;
    wbuf_state_e       next_state_s;

    logic [TAG_W-1:0]  up_tag_s;
    logic [4:0]        unused_addr_s;
    logic [DEPTH-1:0]  match_vec_s;
    logic [PTR_W-1:0]  head_idx_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic [LINE_W-1:0] head_data_s;
    logic [LINE_W-1:0] fwd_data_s;
    logic [CNT_W-1:0]  count_s;

    logic              req_live_s;
    logic              wr_req_s;
    logic              rd_req_s;
    logic              in_flight_s;
    logic              hit_any_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic              coal_hit_s;
    logic [PTR_W-1:0]  coal_idx_s;
    logic [PTR_W-1:0]  idx_v;
    logic              buf_full_s;
    logic              wr_accept_s;
    logic              push_s;
    logic              cwr_s;
    logic              pop_s;
    logic              fwd_s;
    logic              rd_issue_s;
    logic              read_done_s;
    logic              mem_done_s;
    logic              start_drain_s;
    logic              start_read_s;
    logic              use_up_s;
    logic [TAG_W-1:0]  drain_tag_s;
    logic [LINE_W-1:0] drain_data_s;

    logic              up_ack_r;
    logic [LINE_W-1:0] up_data_r;
    logic              mem_enable_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [LINE_W-1:0] mem_data_r;

    assign up_tag_s      = up_addr_i[ADDR_W-1:LINE_OFFSET_W];
    assign unused_addr_s = up_addr_i[LINE_OFFSET_W-1:0];

    // The cycle after an ack belongs to the requester changing its request.
    assign req_live_s  = up_enable_i & ~up_ack_r;
    assign wr_req_s    = req_live_s & up_write_i;
    assign rd_req_s    = req_live_s & ~up_write_i;
    assign in_flight_s = (state_r == DRAIN);

    // Walk entries oldest to youngest: the last hit is the youngest copy for
    // forwarding; the in-flight head is never a merge target so the line
    // being written to memory stays stable.
    always_comb begin
        hit_any_s  = 1'b0;
        fwd_idx_s  = {PTR_W{1'b0}};
        coal_hit_s = 1'b0;
        coal_idx_s = {PTR_W{1'b0}};
        idx_v      = {PTR_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_idx_s + PTR_W'(k);
            if (match_vec_s[idx_v]) begin
                hit_any_s = 1'b1;
                fwd_idx_s = idx_v;
                if (!(in_flight_s && (idx_v == head_idx_s))) begin
                    coal_hit_s = 1'b1;
                    coal_idx_s = idx_v;
                end else begin
                    coal_hit_s = coal_hit_s;
                end
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    assign buf_full_s  = (count_s == CNT_W'(DEPTH));
    assign wr_accept_s = wr_req_s & (coal_hit_s | ~buf_full_s);
    assign push_s      = wr_accept_s & ~coal_hit_s;
    assign cwr_s       = wr_accept_s & coal_hit_s;
    assign pop_s       = in_flight_s & mem_ack_i;
    assign read_done_s = (state_r == READ) & mem_ack_i;
    assign mem_done_s  = (state_r != IDLE) & mem_ack_i;

`ifdef WBUF_FORWARD_EN
    assign fwd_s = rd_req_s & hit_any_s;
`else
    assign fwd_s = 1'b0;
`endif
    // A read touching any buffered line (in-flight head included) must not reach memory.
    assign rd_issue_s = rd_req_s & ~hit_any_s;

    // A drain started in the same cycle as an enqueue into an empty buffer,
    // or a merge into the not-yet-in-flight head, must take the incoming line.
    assign use_up_s     = (count_s == {CNT_W{1'b0}}) | (cwr_s & (coal_idx_s == head_idx_s));
    assign drain_tag_s  = (count_s == {CNT_W{1'b0}}) ? up_tag_s : head_tag_s;
    assign drain_data_s = use_up_s ? up_data_i : head_data_s;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_s),
        .push_tag  (up_tag_s),
        .push_data (up_data_i),
        .pop       (pop_s),
        .cwr       (cwr_s),
        .cwr_idx   (coal_idx_s),
        .cwr_data  (up_data_i),
        .cmp_tag   (up_tag_s),
        .match_vec (match_vec_s),
        .rd_idx    (fwd_idx_s),
        .rd_data   (fwd_data_s),
        .head_idx  (head_idx_s),
        .head_tag  (head_tag_s),
        .head_data (head_data_s),
        .count     (count_s)
    );

    // Downstream state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: read misses win over drains; every request returns to IDLE so
    // mem_enable_o drops for at least one cycle between requests.
    always_comb begin
        next_state_s  = state_r;
        start_drain_s = 1'b0;
        start_read_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_issue_s) begin
                    next_state_s = READ;
                    start_read_s = 1'b1;
                end else if ((count_s != {CNT_W{1'b0}}) || push_s) begin
                    next_state_s  = DRAIN;
                    start_drain_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            READ: begin
                if (mem_ack_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = READ;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Memory request registers, loaded when a request starts and held until mem_ack_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_data_r   <= {LINE_W{1'b0}};
        end else if (start_drain_s) begin
            mem_enable_r <= 1'b1;
            mem_write_r  <= 1'b1;
            mem_addr_r   <= {drain_tag_s, {LINE_OFFSET_W{1'b0}}};
            mem_data_r   <= drain_data_s;
        end else if (start_read_s) begin
            mem_enable_r <= 1'b1;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {up_tag_s, {LINE_OFFSET_W{1'b0}}};
        end else if (mem_done_s) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
        end
    end

    // Upstream ack pulse and returned read line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            up_ack_r  <= 1'b0;
            up_data_r <= {LINE_W{1'b0}};
        end else begin
            up_ack_r <= wr_accept_s | fwd_s | read_done_s;
            if (read_done_s) begin
                up_data_r <= mem_data_i;
            end else if (fwd_s) begin
                up_data_r <= fwd_data_s;
            end
        end
    end

    assign up_ack_o     = up_ack_r;
    assign up_data_o    = up_data_r;
    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Line-granular write buffer between the data cache's memory port and the data memory. It absorbs 256-bit write-backs from the cache, acknowledges them without waiting for memory latency, and drains them to memory in FIFO order. Read misses are serviced by memory, or from a buffered line when forwarding is compiled in. Both sides use the codebase's enable/write/ack memory handshake, so the block drops in transparently on the dcache-to-memory path.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2
- ADDR_W, 32: byte address width
- LINE_W, 256: line width in bits
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- up_enable_i  in  1  cache request valid; held until up_ack_o
- up_write_i  in  1  1 = write-back, 0 = line fill read
- up_addr_i  in  ADDR_W  byte address; bits [4:0] ignored
- up_data_i  in  LINE_W  write line
- up_ack_o  out  1  one-cycle completion pulse
- up_data_o  out  LINE_W  read line; valid while up_ack_o=1
- mem_enable_o  out  1  memory request; held until mem_ack_i
- mem_write_o  out  1  memory request type
- mem_addr_o  out  ADDR_W  line-aligned, bits [4:0]=0
- mem_data_o  out  LINE_W  write line
- mem_ack_i  in  1  memory completion pulse
- mem_data_i  in  LINE_W  read line; valid with mem_ack_i

## Operation
- Entry fields: valid, tag = addr[ADDR_W-1:5], data. Storage is a circular FIFO with head/tail pointers and count 0..DEPTH.
- **Upstream write**
  - Accepted when up_enable_i=1, up_write_i=1, no ack is pending, and either count<DEPTH or a coalesce target exists.
  - Coalesce target: a valid, non-head-in-flight entry with an equal tag. Its data is overwritten and count is unchanged.
  - Otherwise the write is enqueued at the tail.
  - Full with no coalesce target: the request waits, with no ack, until a drain completes.
- **Upstream read**
  - A read matching a buffered tag is handled per WBUF_FORWARD_EN (see Configuration).
  - A non-matching read is issued to memory.
  - The read returns mem_data_i on up_data_o with up_ack_o in the cycle after mem_ack_i.
- **Downstream FSM states:** IDLE, DRAIN, READ.
  - IDLE: a pending non-matching read has priority → READ. Else count>0 → DRAIN head.
  - DRAIN: hold mem_enable_o=1, mem_write_o=1 and the head addr/data. On mem_ack_i, pop head (count−1) and go to IDLE.
  - READ: hold mem_enable_o=1, mem_write_o=0. On mem_ack_i, latch the data, pulse up_ack_o next cycle, and go to IDLE.
- Memory requests are not re-issued back-to-back in the cycle of mem_ack_i; mem_enable_o is 0 for ≥1 cycle between requests.
- The upstream side must drop or change its request in the cycle after up_ack_o. The block ignores up_enable_i in that cycle.
- **Reset:** all valid bits, pointers and count go to 0 and the FSM to IDLE. Every output is 0, including the data buses. An in-flight memory transaction is abandoned.

## Timing
- Accepted write (enqueue or coalesce): up_ack_o exactly 1 cycle after the accepting edge.
- Drain start: mem_enable_o rises 1 cycle after the enqueue edge when IDLE.
- Forwarded read: up_ack_o 1 cycle after the request is sampled.
- Memory read: up_ack_o 1 cycle after mem_ack_i. Total latency = memory latency + 2.
- **Full buffer with a simultaneous drain-ack and new write:**
  - The slot frees at this edge.
  - The write is accepted at the next edge, not the same one.
- **Write to the tag of the in-flight head:** enqueues a new entry (never coalesces), so mem_data_o stays stable.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH, never exceeds it.

## Configuration
- WBUF_FORWARD_EN defined: a read whose tag matches any valid entry returns that entry's data with 1-cycle ack and no memory access. If the match is both the in-flight head and a younger entry, the youngest data wins.
- WBUF_FORWARD_EN undefined: a matching read stalls until no valid entry carries that tag, then is issued to memory as a normal read.

## Structure
- Package dcache_wbuf_pkg:
  - wbuf_state_e enum {IDLE, DRAIN, READ}
  - wbuf_entry_t struct {valid, tag, data}
  - LINE_OFFSET_W = 5 constant
- Sub-module wbuf_fifo: circular storage, head/tail/count, push, pop, coalesce-write port, and combinational per-entry tag match vector.
- Top level holds the FSM, request arbitration, and ack/data registers.

## Test plan
- Write 0x100 into an empty buffer, memory latency 10 → up_ack_o at cycle+1; mem_write_o with mem_addr_o=0x100 from cycle+1 until ack; count back to 0.
- Four writes to 0x000/0x020/0x040/0x060 with memory stalled, then a fifth write to 0x080 → no ack until the first mem_ack_i; fifth ack at mem_ack_i+2 edges.
- Write 0x200 (data A) then 0x200 (data B) while head 0x000 is in flight → count stays 2; memory later receives 0x200 with B only.
- FORWARD_EN: buffered 0x300 (data C), then read 0x300 → up_data_o=C with 1-cycle ack and mem_enable_o untouched. Undefined: the read is issued only after the 0x300 drain ack.
- Read 0x400 (miss) while two writes are queued → the read issues before the queued drains; up_data_o=mem_data_i at mem_ack_i+1.
- Assert rst_i mid-DRAIN → all outputs 0 asynchronously; after release, count=0 and a new write is acked normally.
